serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder: the "other direction" counterpart of the team's one-bit full subtractor.
- Loads two operands plus carry-in on a start strobe and processes one bit per clock, LSB first, through a single full-adder cell and a carry flop.
- Presents the registered sum and carry-out with a one-cycle done pulse.
- Sits beside the combinational arithmetic cells as the area-minimal sequential arithmetic unit.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_full_add_cell.sv | 30 +++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   state_t   - controller states (encoding 2'd3 is unused and recovers to IDLE)
//   cnt_width - bit-counter width for a given operand width (minimum 1 bit)
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_add_cell.sv
// full_add_cell: combinational one-bit add cell used by serial_adder.
//   a, b, c : operand bits and carry-in (borrow-in in subtract mode)
//   sub     : present only with SERIAL_ADDER_SUB_EN; 1 selects subtract
//   s       : sum (difference) bit
//   co      : carry-out (borrow-out in subtract mode)
module full_add_cell (
    input  logic a,
    input  logic b,
    input  logic c,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic sub,
`endif
    output logic s,
    output logic co
);

    always_comb begin
        s = a ^ b ^ c;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            co = (~a & b) | (~(a ^ b) & c);
        end else begin
            co = (a & b) | (a & c) | (b & c);
        end
`else
        co = (a & b) | (a & c) | (b & c);
`endif
    end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//   Optional subtract mode under macro SERIAL_ADDER_SUB_EN (adds port sub_in).
// Ports:
//   clk_in   - clock, rising edge
//   rst_n_in - asynchronous active-low reset
//   start_in - start request, accepted only in IDLE
//   a_in     - operand A, sampled on accepted start
//   b_in     - operand B, sampled on accepted start
//   c_in     - carry-in / borrow-in, sampled on accepted start
//   sub_in   - (SERIAL_ADDER_SUB_EN only) 1 = subtract
//   sum_out  - registered result, updated only on completion
//   c_out    - registered carry-out / borrow-out
//   busy_out - high in RUN and DONE
//   done_out - one-cycle completion pulse
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_in,
`endif
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] a_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             bit_sum;
    logic             bit_co;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_q;
`endif

    full_add_cell u_cell (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .c   (carry),
`ifdef SERIAL_ADDER_SUB_EN
        .sub (sub_q),
`endif
        .s   (bit_sum),
        .co  (bit_co)
    );

    // The A shift register doubles as the result accumulator: each consumed
    // LSB frees the MSB slot that receives the new sum bit, so after WIDTH
    // shifts it holds the complete result.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign a_next = bit_sum;
        end else begin : g_acc_wn
            assign a_next = {bit_sum, a_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum_out  <= '0;
            c_out    <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sh     <= a_in;
                        b_sh     <= b_in;
                        carry    <= c_in;
                        cnt      <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q    <= sub_in;
`endif
                        busy_out <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_next;
                    b_sh  <= b_sh >> 1;
                    carry <= bit_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        sum_out  <= a_next;
                        c_out    <= bit_co;
                        done_out <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder.
//   Drives a WIDTH=8 instance and a WIDTH=1 instance from one clock.
//   Subtract vectors are exercised when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
    logic       sub8;
    logic [7:0] sum8;
    logic       co8;
    logic       busy8;
    logic       done8;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       c1;
    logic       sub1;
    logic [0:0] sum1;
    logic       co1;
    logic       busy1;
    logic       done1;

    int n_checks;
    int n_errors;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start_in (start8),
        .a_in     (a8),
        .b_in     (b8),
        .c_in     (c8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_in   (sub8),
`endif
        .sum_out  (sum8),
        .c_out    (co8),
        .busy_out (busy8),
        .done_out (done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .start_in (start1),
        .a_in     (a1),
        .b_in     (b1),
        .c_in     (c1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_in   (sub1),
`endif
        .sum_out  (sum1),
        .c_out    (co1),
        .busy_out (busy1),
        .done_out (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 operation. inj1/inj2 name the RUN steps (edges after the
    // start edge) before which a spurious start with junk operands is driven.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic sub, input logic [7:0] exp_sum, input logic exp_co,
                       input int inj1, input int inj2);
        logic [7:0] prev_sum;
        logic       prev_co;
        int         n;
        bit         seen;
        prev_sum = sum8;
        prev_co  = co8;
        a8 = a; b8 = b; c8 = c; sub8 = sub;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = ~a; b8 = ~b; c8 = ~c;
        check("busy_after_start", busy8, 1);
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            check("busy_in_run", busy8, 1);
            check("no_partial_sum", sum8, prev_sum);
            check("no_partial_co", co8, prev_co);
            if (n == inj1 || n == inj2) begin
                start8 = 1'b1;
                a8 = 8'hA5; b8 = 8'h5A; c8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            step();
            n++;
            if (done8) seen = 1;
        end
        start8 = 1'b0;
        check("done_latency", n, 8);
        check("sum", sum8, exp_sum);
        check("c_out", co8, exp_co);
        check("busy_in_done", busy8, 1);
        step();
        check("done_one_cycle", done8, 0);
        check("busy_after_done", busy8, 0);
        step();
        check("no_queued_start", busy8, 0);
        check("no_second_done", done8, 0);
        check("sum_holds", sum8, exp_sum);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; sub1 = 1'b0;
        #2;
        check("reset_sum", sum8, 0);
        check("reset_co", co8, 0);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, -1, -1);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, -1, -1);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, -1, -1);
        // start asserted during RUN cycles 3 and 8: ignored, result of 0x3C+0x5A
        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 2, 7);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, -1, -1);

        // asynchronous reset in the middle of RUN
        a8 = 8'h55; b8 = 8'h55; c8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_sum", sum8, 0);
        check("abort_co", co8, 0);
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("abort_no_done", done8, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("after_reset_idle", busy8, 0);
        op8(8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, -1, -1);

        // WIDTH=1: full-adder truth table
        for (int v = 0; v < 8; v++) begin
            logic [2:0] bits;
            logic [1:0] exp;
            bits = 3'(v);
            a1 = bits[2]; b1 = bits[1]; c1 = bits[0];
            exp = 2'(bits[2]) + 2'(bits[1]) + 2'(bits[0]);
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("w1_busy", busy1, 1);
            check("w1_no_early_done", done1, 0);
            step();
            check("w1_done", done1, 1);
            check("w1_result", {co1, sum1}, exp);
            step();
            check("w1_done_drop", done1, 0);
            check("w1_idle", busy1, 0);
        end

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, -1, -1);
        op8(8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b0, -1, -1);
        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, -1, -1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
